// File: rtl/pid_coeff_loader_pkg.sv
// -----------------------------------------------------------------------------
// pid_coeff_loader_pkg
//   Shared definitions for the PID coefficient loader: default field widths,
//   the frame address map, the frame-length helper and the framing FSM states.
// -----------------------------------------------------------------------------
package pid_coeff_loader_pkg;

  localparam int unsigned DEF_REG_BITWIDTH  = 32;
  localparam int unsigned DEF_ADDR_BITWIDTH = 3;

  // Number of coefficient registers (a1, a0, b0, b1, b2).
  localparam int unsigned NUM_COEFFS = 5;

  // Frame address map. Coefficient addresses double as array indices.
  localparam int unsigned ADDR_A1    = 0;
  localparam int unsigned ADDR_A0    = 1;
  localparam int unsigned ADDR_B0    = 2;
  localparam int unsigned ADDR_B1    = 3;
  localparam int unsigned ADDR_B2    = 4;
  localparam int unsigned ADDR_APPLY = 5;

  // A frame is the address field followed by one coefficient word.
  function automatic int unsigned frame_len(input int unsigned addr_bits,
                                            input int unsigned reg_bits);
    return addr_bits + reg_bits;
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(DEF_ADDR_BITWIDTH, DEF_REG_BITWIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/pid_coeff_loader_sync_edge.sv
// -----------------------------------------------------------------------------
// cfg_sync_edge
//   Two-flop synchroniser for an asynchronous pad input, followed by a delay
//   flop used to detect a rising edge of the synchronised level.
//   Ports:
//     clk_i, rstn_i : system clock, asynchronous active-low reset
//     async_i       : asynchronous input
//     sync_o        : synchronised level
//     rise_o        : one-cycle pulse on a 0->1 transition of sync_o
//   RST_VAL sets the idle level all three flops take in reset, so an idle-high
//   line (cs_n) does not produce a false edge when reset releases.
// -----------------------------------------------------------------------------
module cfg_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // NOTE: every variable written here gets a value before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pid_coeff_loader.sv
// -----------------------------------------------------------------------------
// pid_coeff_loader
//   Serial configuration front-end for the PID core. Frames arrive on a
//   3-wire link (cfg_cs_n_i / cfg_sclk_i / cfg_mosi_i), MSB first: an
//   ADDR_BITWIDTH address followed by REG_BITWIDTH data bits. Addresses 0..4
//   load shadow coefficients, address 5 requests an apply, 6..7 are invalid.
//   A pending apply copies all five shadows to the active outputs on the next
//   clk_en_PID_i strobe, so the PID core never sees a partially updated set.
//   Ports:
//     clk_i, rstn_i          : system clock, asynchronous active-low reset
//     clk_en_PID_i           : sample strobe, commit point for a pending apply
//     cfg_cs_n_i/sclk_i/mosi_i : asynchronous serial link
//     err_clr_i              : clears the sticky frame error
//     a1/a0/b0/b1/b2_reg_o   : active signed coefficients (registered)
//     apply_pending_o        : apply requested, waiting for the next strobe
//     frame_err_o            : sticky malformed-frame flag
//     frame_ok_o             : one-cycle pulse for each accepted frame
// -----------------------------------------------------------------------------
module pid_coeff_loader
  import pid_coeff_loader_pkg::*;
#(
  parameter int unsigned REG_BITWIDTH  = DEF_REG_BITWIDTH,
  parameter int unsigned ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter logic signed [REG_BITWIDTH-1:0] A1_RST = '0,
  parameter logic signed [REG_BITWIDTH-1:0] A0_RST = '0,
  parameter logic signed [REG_BITWIDTH-1:0] B0_RST = '0,
  parameter logic signed [REG_BITWIDTH-1:0] B1_RST = '0,
  parameter logic signed [REG_BITWIDTH-1:0] B2_RST = '0
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           clk_en_PID_i,
  input  logic                           cfg_cs_n_i,
  input  logic                           cfg_sclk_i,
  input  logic                           cfg_mosi_i,
  input  logic                           err_clr_i,
  output logic signed [REG_BITWIDTH-1:0] a1_reg_o,
  output logic signed [REG_BITWIDTH-1:0] a0_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b0_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b1_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b2_reg_o,
  output logic                           apply_pending_o,
  output logic                           frame_err_o,
  output logic                           frame_ok_o
);

  localparam int unsigned FRAME_BITS = frame_len(ADDR_BITWIDTH, REG_BITWIDTH);
  // The counter must be able to hold FRAME_BITS+1 so over-length frames are
  // distinguishable from exact-length ones.
  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef logic signed [REG_BITWIDTH-1:0] coeff_t;
  localparam coeff_t RST_VALS [NUM_COEFFS] = '{A1_RST, A0_RST, B0_RST, B1_RST, B2_RST};

  // ---------------------------------------------------------------------------
  // Pad synchronisation
  // ---------------------------------------------------------------------------
  logic sclk_sync, sclk_rise;
  logic cs_n_sync, cs_n_rise;
  logic mosi_meta_q, mosi_meta_d;
  logic mosi_sync_q, mosi_sync_d;

  cfg_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .async_i (cfg_sclk_i),
    .sync_o  (sclk_sync),
    .rise_o  (sclk_rise)
  );

  cfg_sync_edge #(.RST_VAL(1'b1)) u_sync_cs_n (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .async_i (cfg_cs_n_i),
    .sync_o  (cs_n_sync),
    .rise_o  (cs_n_rise)
  );

  // mosi only needs to be stable when the sclk edge is seen; both travel
  // through the same two-flop depth, so no edge detector is needed here.
  always_comb begin
    mosi_meta_d = cfg_mosi_i;
    mosi_sync_d = mosi_meta_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM, shadow / active coefficient banks
  // ---------------------------------------------------------------------------
  cfg_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  coeff_t                shadow_q [NUM_COEFFS];
  coeff_t                shadow_d [NUM_COEFFS];
  coeff_t                active_q [NUM_COEFFS];
  coeff_t                active_d [NUM_COEFFS];
  logic                  pending_q, pending_d;
  logic                  err_q, err_d;
  // ok_q is decided when the frame closes and held through the CHECK cycle,
  // where it both drives frame_ok_o and gates the register update.
  logic                  ok_q, ok_d;

  always_comb begin : next_state
    logic [ADDR_BITWIDTH-1:0] frame_addr;

    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    err_d      = err_q;
    ok_d       = 1'b0;
    frame_addr = shift_q[FRAME_BITS-1 -: ADDR_BITWIDTH];

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    // Commit uses the pre-edge shadow and pending values: a shadow write or
    // apply landing in the same cycle only affects the next commit.
    if (clk_en_PID_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!cs_n_sync) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end

      ST_SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_sync_q};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (cs_n_rise) begin
          state_d    = ST_CHECK;
          frame_addr = shift_d[FRAME_BITS-1 -: ADDR_BITWIDTH];
          ok_d       = (cnt_d == CNT_FULL) && (32'(frame_addr) <= ADDR_APPLY);
        end
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        if (ok_q) begin
          if (32'(frame_addr) == ADDR_APPLY) begin
            pending_d = 1'b1;
          end else begin
            shadow_d[frame_addr] = shift_q[REG_BITWIDTH-1:0];
          end
        end else begin
          // Placed after the clear so a simultaneous error keeps the flag set.
          err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the coefficient banks are a handful of flops, not a RAM, so they
  // take a defined reset value like every other register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      shadow_q  <= RST_VALS;
      active_q  <= RST_VALS;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      ok_q      <= ok_d;
    end
  end

  assign a1_reg_o        = active_q[ADDR_A1];
  assign a0_reg_o        = active_q[ADDR_A0];
  assign b0_reg_o        = active_q[ADDR_B0];
  assign b1_reg_o        = active_q[ADDR_B1];
  assign b2_reg_o        = active_q[ADDR_B2];
  assign apply_pending_o = pending_q;
  assign frame_err_o     = err_q;
  assign frame_ok_o      = ok_q;

  // The synchronised sclk level itself is only needed for edge detection.
  logic unused_ok;
  assign unused_ok = sclk_sync;

endmodule

// File: tb/tb_pid_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_pid_coeff_loader
//   Drives serial frames into pid_coeff_loader and compares every output with
//   a frame-level reference model (shadow/active arrays plus pending/error
//   flags updated per frame and per strobe).
// -----------------------------------------------------------------------------
module tb_pid_coeff_loader;

  localparam int W = 32;
  localparam logic [W-1:0] RST_A1 = 32'h0000_0A11;
  localparam logic [W-1:0] RST_A0 = 32'h0000_0A00;
  localparam logic [W-1:0] RST_B0 = 32'hFFFF_0B00;
  localparam logic [W-1:0] RST_B1 = 32'h0000_0B11;
  localparam logic [W-1:0] RST_B2 = 32'h7000_0B22;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clk_en = 1'b0;
  logic cs_n = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic err_clr = 1'b0;
  logic signed [W-1:0] a1, a0, b0, b1, b2;
  logic pend, ferr, fok;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [W-1:0] rst_vals [5];
  logic [W-1:0] m_shadow [5];
  logic [W-1:0] m_active [5];
  bit m_pending;
  bit m_err;

  always #5 clk = ~clk;

  pid_coeff_loader #(
    .REG_BITWIDTH  (W),
    .ADDR_BITWIDTH (3),
    .A1_RST        (RST_A1),
    .A0_RST        (RST_A0),
    .B0_RST        (RST_B0),
    .B1_RST        (RST_B1),
    .B2_RST        (RST_B2)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .clk_en_PID_i    (clk_en),
    .cfg_cs_n_i      (cs_n),
    .cfg_sclk_i      (sclk),
    .cfg_mosi_i      (mosi),
    .err_clr_i       (err_clr),
    .a1_reg_o        (a1),
    .a0_reg_o        (a0),
    .b0_reg_o        (b0),
    .b1_reg_o        (b1),
    .b2_reg_o        (b2),
    .apply_pending_o (pend),
    .frame_err_o     (ferr),
    .frame_ok_o      (fok)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] observed,
                       input logic [W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] act [5];
    act = '{a1, a0, b0, b1, b2};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s.coef%0d", tag, i), act[i], m_active[i]);
    end
    check({tag, ".pending"}, 32'(pend), 32'(m_pending));
    check({tag, ".err"}, 32'(ferr), 32'(m_err));
  endtask

  task automatic model_reset();
    m_shadow  = rst_vals;
    m_active  = rst_vals;
    m_pending = 1'b0;
    m_err     = 1'b0;
  endtask

  function automatic logic [39:0] mk(input logic [2:0] addr, input logic [31:0] data);
    return {5'b0, addr, data};
  endfunction

  task automatic send_bits(input int n, input logic [39:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  // One complete frame. Optionally raises the strobe and/or error-clear
  // during the frame's check cycle, then updates the model and compares.
  task automatic run_frame(input string tag, input int n, input logic [39:0] bits,
                           input bit strobe, input bit clr);
    bit good;
    logic [2:0] addr;
    addr = bits[34:32];
    good = (n == 35) && (addr <= 3'd5);

    cs_n = 1'b0;
    tick(4);
    send_bits(n, bits);
    tick(4);
    cs_n = 1'b1;
    tick(3);
    check({tag, ".ok"}, 32'(fok), 32'(good));

    clk_en  = strobe;
    err_clr = clr;
    tick(1);
    clk_en  = 1'b0;
    err_clr = 1'b0;

    if (strobe && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (clr) m_err = 1'b0;
    if (good) begin
      if (addr == 3'd5) m_pending = 1'b1;
      else              m_shadow[addr] = bits[31:0];
    end else begin
      m_err = 1'b1;
    end

    check({tag, ".ok_end"}, 32'(fok), 32'd0);
    check_all(tag);
    tick(3);
  endtask

  task automatic strobe(input string tag);
    clk_en = 1'b1;
    tick(1);
    clk_en = 1'b0;
    if (m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] rbits;
    int n;
    int r;

    rst_vals = '{RST_A1, RST_A0, RST_B0, RST_B1, RST_B2};
    model_reset();

    // Reset state.
    tick(3);
    rstn = 1'b1;
    tick(3);
    check_all("reset");
    check("reset.ok", 32'(fok), 32'd0);

    // Shadow write then apply without a strobe, then commit.
    run_frame("wr_b0", 35, mk(3'd2, 32'h0000_1234), 1'b0, 1'b0);
    run_frame("apply1", 35, mk(3'd5, $urandom()), 1'b0, 1'b0);
    tick(5);
    check_all("idle_no_strobe");
    strobe("commit1");
    strobe("strobe_no_pending");

    // Malformed frames: short, long, invalid addresses.
    run_frame("short34", 34, 40'(mk(3'd0, 32'hDEAD_BEEF)), 1'b0, 1'b0);
    clear_err("clr1");
    run_frame("long36", 36, {4'b0, 4'b0001, 32'hCAFE_F00D}, 1'b0, 1'b0);
    run_frame("addr6", 35, mk(3'd6, 32'h1111_2222), 1'b0, 1'b0);
    clear_err("clr2");
    run_frame("addr7_clr", 35, mk(3'd7, 32'h3333_4444), 1'b0, 1'b1);
    clear_err("clr3");
    // Bad frames must not have touched shadows: apply and compare.
    run_frame("apply2", 35, mk(3'd5, 32'h0), 1'b0, 1'b0);
    strobe("commit2");

    // Apply whose check cycle coincides with the strobe.
    run_frame("wr_a0", 35, mk(3'd1, $urandom()), 1'b0, 1'b0);
    run_frame("apply_coinc", 35, mk(3'd5, 32'h0), 1'b1, 1'b0);
    strobe("commit3");

    // Shadow write coinciding with a commit: active gets the old shadow.
    run_frame("wr_b1_a", 35, mk(3'd3, $urandom()), 1'b0, 1'b0);
    run_frame("apply3", 35, mk(3'd5, 32'h0), 1'b0, 1'b0);
    run_frame("wr_b1_commit", 35, mk(3'd3, $urandom()), 1'b1, 1'b0);
    run_frame("apply4", 35, mk(3'd5, 32'h0), 1'b0, 1'b0);
    strobe("commit4");

    // a1 and b2 update together.
    run_frame("wr_a1", 35, mk(3'd0, 32'hFFFF_FFF0), 1'b0, 1'b0);
    run_frame("wr_b2", 35, mk(3'd4, 32'h4000_0000), 1'b0, 1'b0);
    run_frame("apply5", 35, mk(3'd5, 32'h0), 1'b0, 1'b0);
    check_all("pre_commit5");
    strobe("commit5");

    // Randomised frames.
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 5));
      n = (r == 0) ? 34 : (r == 1) ? 36 : 35;
      rbits = {$urandom(), $urandom()};
      rbits[34:32] = 3'($urandom_range(0, 7));
      run_frame($sformatf("rnd%0d", i), n, rbits,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_frame("apply_final", 35, mk(3'd5, 32'h0), 1'b0, 1'b0);
    strobe("commit_final");
    clear_err("clr_final");

    // Reset in the middle of a write, remaining bits after release.
    run_frame("wr_b0_pre", 35, mk(3'd2, 32'h5555_AAAA), 1'b0, 1'b0);
    rbits = mk(3'd4, 32'h0123_4567);
    cs_n = 1'b0;
    tick(4);
    for (int i = 34; i >= 25; i--) begin
      mosi = rbits[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    rstn = 1'b0;
    tick(2);
    model_reset();
    check_all("mid_reset");
    check("mid_reset.ok", 32'(fok), 32'd0);
    rstn = 1'b1;
    send_bits(25, rbits);
    tick(4);
    cs_n = 1'b1;
    tick(3);
    check("tail.ok", 32'(fok), 32'd0);
    tick(1);
    m_err = 1'b1;
    check_all("tail_frame");
    run_frame("apply_after_rst", 35, mk(3'd5, 32'h0), 1'b0, 1'b0);
    strobe("commit_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
